axi_stream_mux_7_arbiter: RTL and testbench

Packet-aware round-robin arbiter that drives the address input of the 7-way registered AXI-stream mux. It watches the valid lines of the seven mux inputs and the handshake on the mux output. It switches the mux only at packet boundaries, so a tlast-terminated packet is never split between sources. Used wherever several producers (ADC frontends, scope channels) share one downstream stream.

---
 rtl/axi_stream_mux_arb_pkg.sv | 13 +
 rtl/rr_next_picker.sv | 25 ++
 rtl/axi_stream_mux_7_arbiter.sv | 97 +++++++++
 tb/tb_axi_stream_mux_7_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_mux_arb_pkg.sv
// axi_stream_mux_arb_pkg: shared types, sizes and the wrap-around index helper for the mux arbiter
package axi_stream_mux_arb_pkg;
  localparam int N_INPUTS   = 7;
  localparam int ADDR_WIDTH = 3;
  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED, RELEASE} arb_state_t;
  function automatic logic [ADDR_WIDTH-1:0] rr_wrap(input logic [ADDR_WIDTH-1:0] base,
                                                    input logic [ADDR_WIDTH:0] off);
    logic [ADDR_WIDTH:0] s;
    s = {1'b0, base} + off;
    return (s >= (ADDR_WIDTH+1)'(N_INPUTS)) ? ADDR_WIDTH'(s - (ADDR_WIDTH+1)'(N_INPUTS))
                                            : s[ADDR_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/rr_next_picker.sv
// rr_next_picker: first requester strictly after last, wrapping 6->0
//   req   - request vector, bit i = source i
//   last  - previously granted source
//   next  - chosen source (valid when found)
//   found - at least one request present
module rr_next_picker
  import axi_stream_mux_arb_pkg::*;
(
  input  logic [N_INPUTS-1:0]   req,
  input  logic [ADDR_WIDTH-1:0] last,
  output logic [ADDR_WIDTH-1:0] next,
  output logic                  found
);
  logic [N_INPUTS-1:0]   rot;
  logic [ADDR_WIDTH-1:0] off;
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_INPUTS; i++) rot[i] = req[rr_wrap(last, (ADDR_WIDTH+1)'(i + 1))];
    off = '0;
    // scanning downwards leaves the lowest rotated offset, i.e. the nearest source after last
    for (int i = N_INPUTS - 1; i >= 0; i--) if (rot[i]) off = ADDR_WIDTH'(i);
    found = |rot;
    next  = rr_wrap(last, {1'b0, off} + 1'b1);
  end
endmodule

// File: rtl/axi_stream_mux_7_arbiter.sv
// axi_stream_mux_7_arbiter: packet-aware round-robin select for the 7-way registered AXI-stream mux
//   clock, reset (async, active-low)
//   enable, channel_mask, in_valid      - arbitration request side
//   mon_valid, mon_ready, mon_tlast     - handshake observed on the mux output
//   timeout                             - stall cycles before forced release, 0 disables
//   address, grant_valid, timeout_pulse, packet_count - select and status
module axi_stream_mux_7_arbiter
  import axi_stream_mux_arb_pkg::*;
#(
  parameter int TIMEOUT_WIDTH = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_INPUTS-1:0]      channel_mask,
  input  logic [N_INPUTS-1:0]      in_valid,
  input  logic                     mon_valid,
  input  logic                     mon_ready,
  input  logic                     mon_tlast,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  output logic [ADDR_WIDTH-1:0]    address,
  output logic                     grant_valid,
  output logic                     timeout_pulse,
  output logic [31:0]              packet_count
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  arb_state_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0]    address_q, address_d, last_grant_q, last_grant_d, pick;
  logic                     grant_valid_q, grant_valid_d, timeout_pulse_q, timeout_pulse_d, found;
  logic [31:0]              packet_count_q, packet_count_d;
  logic [SW-1:0]            settle_cnt_q, settle_cnt_d;
  logic [TIMEOUT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, stall_inc;
  logic                     hs, hs_last, settle_done, start, to_hit, locked;
  rr_next_picker u_pick (
    .req   (in_valid & channel_mask),
    .last  (last_grant_q),
    .next  (pick),
    .found (found)
  );
  assign hs          = mon_valid & mon_ready;
  assign hs_last     = hs & mon_tlast;
  assign locked      = state_q == LOCKED;
  assign start       = state_q == IDLE && enable && found;
  assign settle_done = settle_cnt_q == SW'(SETTLE_CYCLES - 1);
  assign stall_inc   = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
  // a stall cycle that brings the counter up to the limit forces release; any handshake is progress
  assign to_hit      = locked && !hs && timeout != '0 && stall_inc >= timeout;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      address_q       <= '0;
      last_grant_q    <= ADDR_WIDTH'(N_INPUTS - 1);
      grant_valid_q   <= 1'b0;
      timeout_pulse_q <= 1'b0;
      packet_count_q  <= '0;
      settle_cnt_q    <= '0;
      stall_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      address_q       <= address_d;
      last_grant_q    <= last_grant_d;
      grant_valid_q   <= grant_valid_d;
      timeout_pulse_q <= timeout_pulse_d;
      packet_count_q  <= packet_count_d;
      settle_cnt_q    <= settle_cnt_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? SETTLE : IDLE;
      SETTLE:  state_d = settle_done ? LOCKED : SETTLE;
      LOCKED:  state_d = (hs_last || to_hit) ? RELEASE : LOCKED;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    address_d       = start ? pick : address_q;
    last_grant_d    = state_q == RELEASE ? address_q : last_grant_q;
    settle_cnt_d    = state_q == SETTLE ? settle_cnt_q + 1'b1 : '0;
    stall_cnt_d     = locked ? (hs ? '0 : stall_inc) : '0;
    // grant drops on the releasing edge so it is already low throughout RELEASE
    grant_valid_d   = state_q == SETTLE ? settle_done : locked && !(hs_last || to_hit);
    timeout_pulse_d = to_hit;
    // tlast beats during SETTLE still belong to a finished packet and are counted
    packet_count_d  = packet_count_q + {31'b0, (state_q == SETTLE || locked) && hs_last};
  end
  always_comb begin
    address       = address_q;
    grant_valid   = grant_valid_q;
    timeout_pulse = timeout_pulse_q;
    packet_count  = packet_count_q;
  end
endmodule

// File: tb/tb_axi_stream_mux_7_arbiter.sv
// tb_axi_stream_mux_7_arbiter: directed scenario bench for the packet-aware mux arbiter
module tb_axi_stream_mux_7_arbiter;
  logic        clock = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [6:0]  channel_mask = '0, in_valid = '0;
  logic        mon_valid = 1'b0, mon_ready = 1'b0, mon_tlast = 1'b0;
  logic [15:0] timeout = '0;
  logic [2:0]  address;
  logic        grant_valid, timeout_pulse;
  logic [31:0] packet_count;
  int          n_cmp = 0, n_bad = 0;
  axi_stream_mux_7_arbiter dut (
    .clock(clock), .reset(reset), .enable(enable), .channel_mask(channel_mask),
    .in_valid(in_valid), .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_tlast(mon_tlast),
    .timeout(timeout), .address(address), .grant_valid(grant_valid),
    .timeout_pulse(timeout_pulse), .packet_count(packet_count)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (grant_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask
  task automatic tlast_beat;
    mon_valid = 1'b1; mon_ready = 1'b1; mon_tlast = 1'b1;
    tick();
    mon_valid = 1'b0; mon_ready = 1'b0; mon_tlast = 1'b0;
  endtask
  task automatic test_reset;
    tick(2);
    n_cmp++;
    if ({address, grant_valid, timeout_pulse, packet_count} !== 37'd0) begin
      n_bad++;
      $display("FAIL reset_state addr=%0d gv=%0b tp=%0b cnt=%0d want 0/0/0/0",
               address, grant_valid, timeout_pulse, packet_count);
    end
    reset = 1'b1;
    tick();
  endtask
  task automatic test_single;
    enable = 1'b1; channel_mask = 7'h7f; in_valid = 7'b0000100;
    tick();
    n_cmp++;
    if (address !== 3'd2 || grant_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_addr addr=%0d gv=%0b want addr=2 gv=0", address, grant_valid);
    end
    tick();
    n_cmp++;
    if (grant_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_settle gv=%0b want 0", grant_valid);
    end
    tick();
    n_cmp++;
    if (grant_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL single_grant gv=%0b want 1", grant_valid);
    end
    in_valid = '0;
    tlast_beat();
    n_cmp++;
    if (packet_count !== 32'd1 || grant_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_release cnt=%0d gv=%0b want cnt=1 gv=0", packet_count, grant_valid);
    end
  endtask
  task automatic test_round_robin;
    bit         ok;
    logic [2:0] exp_seq [3] = '{3'd2, 3'd6, 3'd0};
    in_valid = 7'b0000001;
    wait_grant(ok);
    n_cmp++;
    if (!ok || address !== 3'd0) begin
      n_bad++;
      $display("FAIL rr_seed addr=%0d gv=%0b want addr=0 gv=1", address, grant_valid);
    end
    tlast_beat();
    in_valid = 7'b1000101;
    for (int j = 0; j < 3; j++) begin
      wait_grant(ok);
      n_cmp++;
      if (!ok || address !== exp_seq[j]) begin
        n_bad++;
        $display("FAIL rr_grant%0d addr=%0d gv=%0b want addr=%0d gv=1", j, address, grant_valid, exp_seq[j]);
      end
      for (int s = 0; s < 3; s++) begin
        tick();
        n_cmp++;
        if (address !== exp_seq[j] || grant_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL rr_hold%0d addr=%0d gv=%0b want addr=%0d gv=1", j, address, grant_valid, exp_seq[j]);
        end
      end
      tlast_beat();
      n_cmp++;
      if (packet_count !== 32'(3 + j) || grant_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_done%0d cnt=%0d gv=%0b want cnt=%0d gv=0", j, packet_count, grant_valid, 3 + j);
      end
    end
  endtask
  task automatic test_timeout;
    bit ok;
    timeout = 16'd10;
    wait_grant(ok);
    n_cmp++;
    if (!ok || address !== 3'd2) begin
      n_bad++;
      $display("FAIL to_grant addr=%0d gv=%0b want addr=2 gv=1", address, grant_valid);
    end
    mon_valid = 1'b1; mon_ready = 1'b0;
    tick(9);
    n_cmp++;
    if (grant_valid !== 1'b1 || timeout_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL to_early gv=%0b tp=%0b want gv=1 tp=0", grant_valid, timeout_pulse);
    end
    tick();
    n_cmp++;
    if (timeout_pulse !== 1'b1 || grant_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL to_pulse tp=%0b gv=%0b want tp=1 gv=0", timeout_pulse, grant_valid);
    end
    tick();
    n_cmp++;
    if (timeout_pulse !== 1'b0 || packet_count !== 32'd5) begin
      n_bad++;
      $display("FAIL to_after tp=%0b cnt=%0d want tp=0 cnt=5", timeout_pulse, packet_count);
    end
    mon_valid = 1'b0;
    wait_grant(ok);
    n_cmp++;
    if (!ok || address !== 3'd6) begin
      n_bad++;
      $display("FAIL to_next addr=%0d gv=%0b want addr=6 gv=1", address, grant_valid);
    end
    tlast_beat();
    n_cmp++;
    if (packet_count !== 32'd6) begin
      n_bad++;
      $display("FAIL to_next_done cnt=%0d want 6", packet_count);
    end
  endtask
  task automatic test_tlast_vs_timeout;
    bit ok;
    wait_grant(ok);
    n_cmp++;
    if (!ok || address !== 3'd0) begin
      n_bad++;
      $display("FAIL race_grant addr=%0d gv=%0b want addr=0 gv=1", address, grant_valid);
    end
    tick(9);
    n_cmp++;
    if (grant_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL race_hold gv=%0b want 1", grant_valid);
    end
    tlast_beat();
    n_cmp++;
    if (timeout_pulse !== 1'b0 || packet_count !== 32'd7 || grant_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL race_release tp=%0b cnt=%0d gv=%0b want tp=0 cnt=7 gv=0",
               timeout_pulse, packet_count, grant_valid);
    end
    tick();
    n_cmp++;
    if (timeout_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL race_nopulse tp=%0b want 0", timeout_pulse);
    end
    timeout = '0;
  endtask
  task automatic test_mask_enable;
    bit ok;
    channel_mask = 7'b0000001; in_valid = 7'h7f;
    wait_grant(ok);
    n_cmp++;
    if (!ok || address !== 3'd0) begin
      n_bad++;
      $display("FAIL mask_grant addr=%0d gv=%0b want addr=0 gv=1", address, grant_valid);
    end
    tlast_beat();
    n_cmp++;
    if (packet_count !== 32'd8) begin
      n_bad++;
      $display("FAIL mask_done cnt=%0d want 8", packet_count);
    end
    channel_mask = 7'h7f; enable = 1'b0;
    tick(8);
    n_cmp++;
    if (grant_valid !== 1'b0 || address !== 3'd0) begin
      n_bad++;
      $display("FAIL disabled gv=%0b addr=%0d want gv=0 addr=0", grant_valid, address);
    end
    enable = 1'b1;
    wait_grant(ok);
    n_cmp++;
    if (!ok || address !== 3'd1) begin
      n_bad++;
      $display("FAIL en_grant addr=%0d gv=%0b want addr=1 gv=1", address, grant_valid);
    end
    enable = 1'b0;
    tick(3);
    n_cmp++;
    if (grant_valid !== 1'b1 || address !== 3'd1) begin
      n_bad++;
      $display("FAIL en_drop_hold gv=%0b addr=%0d want gv=1 addr=1", grant_valid, address);
    end
    tlast_beat();
    n_cmp++;
    if (packet_count !== 32'd9 || grant_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL en_drop_done cnt=%0d gv=%0b want cnt=9 gv=0", packet_count, grant_valid);
    end
    tick(8);
    n_cmp++;
    if (grant_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL en_no_regrant gv=%0b want 0", grant_valid);
    end
  endtask
  task automatic test_reset_mid_packet;
    bit ok;
    enable = 1'b1;
    wait_grant(ok);
    n_cmp++;
    if (!ok || address !== 3'd2) begin
      n_bad++;
      $display("FAIL rst_grant addr=%0d gv=%0b want addr=2 gv=1", address, grant_valid);
    end
    mon_valid = 1'b1;
    tick(2);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (address !== 3'd0 || grant_valid !== 1'b0 || timeout_pulse !== 1'b0 || packet_count !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_async addr=%0d gv=%0b tp=%0b cnt=%0d want 0/0/0/0",
               address, grant_valid, timeout_pulse, packet_count);
    end
    mon_valid = 1'b0;
    tick(2);
    reset = 1'b1;
    wait_grant(ok);
    n_cmp++;
    if (!ok || address !== 3'd0) begin
      n_bad++;
      $display("FAIL rst_rescan addr=%0d gv=%0b want addr=0 gv=1", address, grant_valid);
    end
    tlast_beat();
    n_cmp++;
    if (packet_count !== 32'd1) begin
      n_bad++;
      $display("FAIL rst_count cnt=%0d want 1", packet_count);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_tlast_vs_timeout();
    test_mask_enable();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
